// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives the DAC trial code, samples a
// synchronized comparator once per bit (MSB first) and reports the code with start/busy/done.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       state_dbg
);

  // Handshake: start is level-sampled only in IDLE; busy is high for the whole
  // conversion; done is a single-cycle pulse coinciding with the new result.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0]    IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_TOP  = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DECIDE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       trial_q;
  logic [IW-1:0]          bit_idx_q;
  logic [CW-1:0]          cnt_q;
  logic [WIDTH-1:0]       result_q;
  logic                   busy_q;
  logic                   done_q;
  logic [SYNC_STAGES-1:0] sync_q;

  logic                   cmp_s;
  logic [WIDTH-1:0]       trial_keep;
  logic [WIDTH-1:0]       trial_d;

  assign cmp_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
    end
  end

  // trial_keep resolves the current bit; trial_d also raises the next probe bit.
  always_comb begin
    trial_keep = trial_q;
    if (!cmp_s) begin
      trial_keep[bit_idx_q] = 1'b0;
    end
    trial_d = trial_keep;
    if (bit_idx_q != '0) begin
      trial_d[bit_idx_q - 1'b1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      trial_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            trial_q   <= MSB_CODE;
            bit_idx_q <= IDX_TOP;
            cnt_q     <= CNT_TOP;
            busy_q    <= 1'b1;
            state_q   <= S_SETTLE;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= S_DECIDE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DECIDE: begin
          if (bit_idx_q != '0) begin
            trial_q   <= trial_d;
            bit_idx_q <= bit_idx_q - 1'b1;
            cnt_q     <= CNT_TOP;
            state_q   <= S_SETTLE;
          end else begin
            trial_q  <= trial_keep;
            result_q <= trial_keep;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dac_out   = trial_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: behavioural comparator, result scoreboard and
// latency/handshake checks on a default instance and a short-settle instance.
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start3;
  logic [7:0] vin;
  logic       noise_en, noise_bit;
  logic       sel;

  logic       cmp_in, cmp3;
  logic [7:0] dac_out, result, dac3, result3;
  logic       busy, done, busy3, done3;
  logic [1:0] state_dbg, state_dbg3;

  logic [7:0] o_dac, o_result;
  logic       o_busy, o_done;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // Comparator model: 1 when Vin >= Vdac; the short-settle instance may see noise.
  assign cmp_in = (vin >= dac_out);
  assign cmp3   = noise_en ? noise_bit : (vin >= dac3);

  assign o_dac    = sel ? dac3 : dac_out;
  assign o_result = sel ? result3 : result;
  assign o_busy   = sel ? busy3 : busy;
  assign o_done   = sel ? done3 : done;

  sar_adc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cmp_in    (cmp_in),
    .dac_out   (dac_out),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  sar_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(3), .SYNC_STAGES(2)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .start     (start3),
    .cmp_in    (cmp3),
    .dac_out   (dac3),
    .busy      (busy3),
    .done      (done3),
    .result    (result3),
    .state_dbg (state_dbg3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One conversion on the selected instance; expected trial codes come from a
  // floor-quantizing binary search model of the analog input.
  task automatic run_conv(input logic s, input logic [7:0] v, input int settle,
                          input logic noisy, input int pulse_at);
    logic [7:0] code;
    logic [7:0] trial;
    logic [7:0] seq[8];
    logic [7:0] e;
    int         c;
    int         per;
    sel  = s;
    vin  = v;
    code = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      trial      = code | (8'h01 << k);
      seq[7 - k] = trial;
      if (v >= trial) code = trial;
    end
    exp_q.push_back(code);
    per = settle + 1;
    @(negedge clk);
    if (s) start3 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start3 = 1'b0;
    c = 0;
    while (o_busy && c < 2000) begin
      if ((c % per == 0) && (c / per < 8)) check_eq("dac_step", o_dac, seq[c / per]);
      if (noisy) begin
        noise_en  = (c % per == 0) || (c % per == 2);
        noise_bit = 1'($urandom_range(0, 1));
      end
      start = (!s && c == pulse_at);
      @(negedge clk);
      c++;
    end
    noise_en = 1'b0;
    start    = 1'b0;
    check_eq("busy_len", c, 8 * per);
    check_eq("done_pulse", o_done, 1);
    e = exp_q.pop_front();
    check_eq("result", o_result, e);
    @(negedge clk);
    check_eq("done_clear", o_done, 0);
    check_eq("idle_busy", o_busy, 0);
  endtask

  initial begin
    int         cyc;
    int         nd;
    int         t[3];
    logic [7:0] e;

    reset = 1'b1; start = 1'b0; start3 = 1'b0; vin = 8'h00;
    noise_en = 1'b0; noise_bit = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_dac", dac_out, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dac3", dac3, 0);
    check_eq("rst_busy3", busy3, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("idle_dac", dac_out, 0);
    check_eq("idle_result", result, 0);
    check_eq("idle_busy0", busy, 0);
    check_eq("idle_done0", done, 0);
    check_eq("idle_state", state_dbg, 0);

    run_conv(1'b0, 8'hA5, 16, 1'b0, -1);
    run_conv(1'b0, 8'h00, 16, 1'b0, -1);
    run_conv(1'b0, 8'hFF, 16, 1'b0, -1);
    run_conv(1'b0, 8'h80, 16, 1'b0, -1);

    // A second start mid-conversion must be ignored: one done, then quiet.
    run_conv(1'b0, 8'h37, 16, 1'b0, 50);
    nd = 0;
    repeat (150) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check_eq("no_queued_start", nd, 0);

    // start held high: back-to-back conversions, one IDLE cycle between.
    sel = 1'b0;
    vin = 8'h5C;
    repeat (3) exp_q.push_back(8'h5C);
    start = 1'b1;
    cyc = 0;
    nd = 0;
    while (nd < 3 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        e = exp_q.pop_front();
        check_eq("held_result", result, e);
        t[nd] = cyc;
        nd++;
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq("held_dones", nd, 3);
    if (nd == 3) begin
      check_eq("held_space1", t[1] - t[0], 138);
      check_eq("held_space2", t[2] - t[1], 138);
    end
    exp_q.delete();
    repeat (5) @(negedge clk);
    check_eq("held_stop", busy, 0);

    // Reset during the fourth bit's settle window.
    vin = 8'h77;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (55) @(negedge clk);
    check_eq("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_eq("abort_dac", dac_out, 0);
    check_eq("abort_result", result, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check_eq("abort_no_done", nd, 0);
    run_conv(1'b0, 8'h3C, 16, 1'b0, -1);

    // Short-settle instance, with comparator noise confined to settle cycles.
    run_conv(1'b1, 8'h5A, 3, 1'b1, -1);
    run_conv(1'b1, 8'hC3, 3, 1'b1, -1);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
